// File: rtl/mem_port_arbiter.sv
// Two-port (CPU / debug) arbiter in front of a single-ported unified memory with fixed wait states.
// Optional build macro DBG_PRIORITY_EN: a pending debug request always wins instead of round-robin.
module mem_port_arbiter #(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          grant_dbg_q;
  logic          last_dbg_q;
  logic          we_q;
  logic          mem_we_q;
  logic          cpu_ack_q;
  logic          dbg_ack_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] dbg_rdata_q;

  logic          grant_dbg_d;
  logic          sel_we_d;
  logic [AW-1:0] sel_addr_d;
  logic [DW-1:0] sel_wdata_d;

  // Arbitration and payload selection for the IDLE grant decision
  always_comb begin
    grant_dbg_d = 1'b0;
`ifdef DBG_PRIORITY_EN
    grant_dbg_d = dbg_req;
`else
    grant_dbg_d = dbg_req & (~cpu_req | ~last_dbg_q);
`endif
    sel_we_d    = grant_dbg_d ? dbg_we    : cpu_we;
    sel_addr_d  = grant_dbg_d ? dbg_addr  : cpu_addr;
    sel_wdata_d = grant_dbg_d ? dbg_wdata : cpu_wdata;
  end

  // Access sequencer: IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE (ack) -> IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      grant_dbg_q <= 1'b0;
      last_dbg_q  <= 1'b1;
      we_q        <= 1'b0;
      mem_we_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      mem_we_q  <= 1'b0;
      cpu_ack_q <= 1'b0;
      dbg_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cpu_req | dbg_req) begin
            grant_dbg_q <= grant_dbg_d;
            we_q        <= sel_we_d;
            mem_addr_q  <= sel_addr_d;
            mem_wdata_q <= sel_wdata_d;
            cnt_q       <= CW'(WAIT_CYCLES - 1);
            // The write strobe must land exactly on the cnt==0 cycle
            mem_we_q    <= sel_we_d & (WAIT_CYCLES == 1);
            state_q     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt_q == '0) begin
            if (!we_q) begin
              if (grant_dbg_q) dbg_rdata_q <= mem_rdata;
              else             cpu_rdata_q <= mem_rdata;
            end
            cpu_ack_q <= ~grant_dbg_q;
            dbg_ack_q <= grant_dbg_q;
            state_q   <= S_DONE;
          end else begin
            cnt_q    <= cnt_q - CW'(1);
            mem_we_q <= we_q & (cnt_q == CW'(1));
          end
        end
        S_DONE: begin
          last_dbg_q <= grant_dbg_q;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign dbg_ack   = dbg_ack_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule
